csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
Machine/supervisor CSR storage. It sits on the responder side of the trap controller's CSR write channel (csr_write_en/addr/data) and of the WB-stage Zicsr write path. It exports every CSR the trap controller reads, plus the current privilege level. It also provides a combinational read port for the EX stage, a free-running mcycle counter and a minstret counter.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
MISA_VAL, 32'h40141105, read-only misa (RV32 IMACSU)
SSTATUS_MASK, 32'h000C0122, mstatus bits visible/writable through sstatus (SIE, SPIE, SPP, SUM, MXR)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
trap_we_i  input  1  trap-controller CSR write enable
trap_waddr_i  input  12  trap-controller CSR address
trap_wdata_i  input  32  trap-controller write data
inst_we_i  input  1  Zicsr instruction write enable (WB stage)
inst_waddr_i  input  12  instruction CSR write address
inst_wdata_i  input  32  instruction write data, already combined (rw/rs/rc) upstream
raddr_i  input  12  EX-stage read address
rdata_o  output  32  combinational read data
illegal_o  output  1  raddr_i unimplemented, under-privileged, or (inst_we_i with read-only inst_waddr_i)
priv_we_i  input  1  privilege update strobe
priv_i  input  2  new privilege level
mtip_i  input  1  machine timer pending level from mtime
retire_i  input  1  one instruction retired this cycle
csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, csr_mie_o, csr_mip_o  output  32 each  M-mode views
csr_medeleg_o, csr_mideleg_o, csr_stvec_o, csr_sepc_o, csr_scause_o, csr_stval_o  output  32 each  delegation/S-mode regs
csr_sstatus_o, csr_sie_o, csr_sip_o, csr_satp_o  output  32 each  S-mode views
csr_privilege_o  output  2  current privilege level

Behaviour:
- Reset:
  - mstatus=32'h00001800 (MPP=M).
  - Every other storage register, mcycle and minstret = 0.
  - priv=2'b11.
  - All outputs reflect these values while rst is high.
- Write timing and port priority:
  - Writes take effect at the next posedge and are visible on outputs in the following cycle. No same-cycle bypass: a read of an address being written returns the old value.
  - Trap port has priority. If trap_we_i and inst_we_i are both high, only the trap write is applied and the instruction write is dropped (not deferred).
  - If both ports target the same register, the trap value wins.
- Privilege checks apply only to the instruction port:
  - The write is ignored if inst_waddr_i[11:10]==2'b11 (read-only) or priv < inst_waddr_i[9:8]. illegal_o is asserted in either case.
  - Trap-port writes are never rejected.
- mstatus:
  - Writable bits: 1, 3, 5, 7, 8, 12:11, 18, 19. All other bits read 0.
  - A write of MPP=2'b10 stores 2'b00 (WARL).
- sstatus: reads mstatus & SSTATUS_MASK; writes modify only the masked bits of mstatus.
- mie/mip:
  - mie writable bits are 1, 5, 7, 9, 11, 3.
  - mip storage writable bits are 1, 5, 7.
  - Read value csr_mip_o = mip_q | (mtip_i<<7).
- sie/sip: sie = mie & mideleg; sip = mip & mideleg. Writes update only the mie/mip bits where mideleg=1.
- Delegation registers:
  - mideleg writable bits: 1, 5, 9.
  - medeleg: bit 11 and bits 31:16 hardwired 0.
- Trap vectors and PCs:
  - mepc/sepc: bit 0 forced 0.
  - mtvec/stvec: if wdata[1:0] >= 2, the mode field keeps its old value and the base field [31:2] is updated normally.
- Counters:
  - mcycle (0xB00/0xB80, read-only aliases 0xC00/0xC80) is 64-bit and increments every cycle; it wraps from all-ones to 0.
  - A write to one half loads that half with wdata and suppresses the increment of the whole counter that cycle; the other half is unchanged.
  - minstret (0xB02/0xB82, aliases 0xC02/0xC82) follows the same rules, but increments only when retire_i=1.
- Read-only registers: misa (0x301)=MISA_VAL; mhartid=HART_ID; mvendorid, marchid and mimpid read 0.
- Privilege: priv register loads priv_i on priv_we_i; it holds otherwise.
- Unimplemented addresses: read 0 with illegal_o=1; writes to them are ignored.
- Reset asserted mid-sequence (e.g. between the trap controller's SAVE_PC and UPDATE_STATUS writes): all state returns to reset values immediately; no partial trap state survives.

Test Plan:
1. Reset, then read 0x300 and 0xF14 -> rdata 0x00001800 and 0 with illegal_o=0; csr_privilege_o=2'b11.
2. Trap sequence: writes 0x341=0x80000101, 0x342=0x80000007, 0x300=0x00001880 on consecutive cycles -> mepc=0x80000100, mcause=0x80000007, mstatus=0x00001880, each visible one cycle after its write.
3. Same cycle: trap_we_i writes 0x341=0x100 and inst_we_i writes 0x341=0x200 -> mepc=0x100; next cycle, with no writes, mepc is still 0x100.
4. mideleg=0x222, mie=0; instruction write 0x104=0xFFFFFFFF -> mie=0x222, sie=0x222. Then with mtip_i=1 -> mip[7]=1 and sip[7]=0.
5. Instruction write 0x300=0x00001000 (MPP=2'b10) -> MPP reads 2'b00. With priv=U, read of 0x300 -> illegal_o=1; write 0xC00 -> ignored with illegal_o=1.
6. Write mcycle low=0xFFFFFFFF, mcycleh=0 -> after 1 idle cycle mcycle=0x00000001_00000000. mtvec write 0x80000003 -> mtvec=0x80000000 (mode retained 0).

Source files
------------

// File: rtl/csr_regfile.sv
// Machine/supervisor CSR storage: trap-controller and Zicsr write ports,
// EX-stage combinational read port, mcycle/minstret counters, privilege level.
module csr_regfile #(
  parameter logic [31:0] HART_ID      = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL     = 32'h4014_1105,
  parameter logic [31:0] SSTATUS_MASK = 32'h000C_0122
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_we_i,
  input  logic [11:0] trap_waddr_i,
  input  logic [31:0] trap_wdata_i,
  input  logic        inst_we_i,
  input  logic [11:0] inst_waddr_i,
  input  logic [31:0] inst_wdata_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  output logic        illegal_o,
  input  logic        priv_we_i,
  input  logic [1:0]  priv_i,
  input  logic        mtip_i,
  input  logic        retire_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_medeleg_o,
  output logic [31:0] csr_mideleg_o,
  output logic [31:0] csr_stvec_o,
  output logic [31:0] csr_sepc_o,
  output logic [31:0] csr_scause_o,
  output logic [31:0] csr_stval_o,
  output logic [31:0] csr_sstatus_o,
  output logic [31:0] csr_sie_o,
  output logic [31:0] csr_sip_o,
  output logic [31:0] csr_satp_o,
  output logic [1:0]  csr_privilege_o
);

  localparam logic [31:0] MSTATUS_WMASK = 32'h000C_19AA;
  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0AAA;
  localparam logic [31:0] MIP_MASK      = 32'h0000_00A2;
  localparam logic [31:0] MIDELEG_MASK  = 32'h0000_0222;
  localparam logic [31:0] MEDELEG_MASK  = 32'h0000_F7FF;

  logic [31:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, mie_q, mie_d;
  logic [31:0] mip_q, mip_d, medeleg_q, medeleg_d, mideleg_q, mideleg_d;
  logic [31:0] stvec_q, stvec_d, sepc_q, sepc_d, scause_q, scause_d;
  logic [31:0] stval_q, stval_d, satp_q, satp_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [1:0]  priv_q, priv_d;

  logic        inst_ro, inst_upriv, inst_ok;
  logic        wen;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic [31:0] mip_rd;
  logic        rd_impl;

  // Instruction-port legality and single merged write port (trap port wins)
  always_comb begin
    inst_ro    = (inst_waddr_i[11:10] == 2'b11);
    inst_upriv = (priv_q < inst_waddr_i[9:8]);
    inst_ok    = inst_we_i & ~inst_ro & ~inst_upriv;
    wen        = trap_we_i | inst_ok;
    waddr      = trap_we_i ? trap_waddr_i : inst_waddr_i;
    wdata      = trap_we_i ? trap_wdata_i : inst_wdata_i;
  end

  assign mip_rd = mip_q | {24'h0, mtip_i, 7'h0};

  // Next-state: counters advance unless loaded, then apply the write
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mie_d      = mie_q;
    mip_d      = mip_q;
    medeleg_d  = medeleg_q;
    mideleg_d  = mideleg_q;
    stvec_d    = stvec_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
    stval_d    = stval_q;
    satp_d     = satp_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(retire_i);
    priv_d     = priv_we_i ? priv_i : priv_q;
    if (wen) begin
      case (waddr)
        12'h300: begin
          mstatus_d = wdata & MSTATUS_WMASK;
          if (wdata[12:11] == 2'b10) mstatus_d[12:11] = 2'b00;
        end
        12'h100: mstatus_d = (mstatus_q & ~(SSTATUS_MASK & MSTATUS_WMASK))
                           | (wdata & SSTATUS_MASK & MSTATUS_WMASK);
        12'h302: medeleg_d = wdata & MEDELEG_MASK;
        12'h303: mideleg_d = wdata & MIDELEG_MASK;
        12'h304: mie_d     = wdata & MIE_MASK;
        12'h104: mie_d     = (mie_q & ~mideleg_q) | (wdata & mideleg_q & MIE_MASK);
        12'h344: mip_d     = wdata & MIP_MASK;
        12'h144: mip_d     = (mip_q & ~mideleg_q) | (wdata & mideleg_q & MIP_MASK);
        12'h305: mtvec_d   = {wdata[31:2], wdata[1] ? mtvec_q[1:0] : wdata[1:0]};
        12'h105: stvec_d   = {wdata[31:2], wdata[1] ? stvec_q[1:0] : wdata[1:0]};
        12'h341: mepc_d    = {wdata[31:1], 1'b0};
        12'h141: sepc_d    = {wdata[31:1], 1'b0};
        12'h342: mcause_d  = wdata;
        12'h343: mtval_d   = wdata;
        12'h142: scause_d  = wdata;
        12'h143: stval_d   = wdata;
        12'h180: satp_d    = wdata;
        12'hB00: mcycle_d   = {mcycle_q[63:32], wdata};
        12'hB80: mcycle_d   = {wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wdata};
        12'hB82: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mie_q      <= '0;
      mip_q      <= '0;
      medeleg_q  <= '0;
      mideleg_q  <= '0;
      stvec_q    <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      stval_q    <= '0;
      satp_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      priv_q     <= 2'b11;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      medeleg_q  <= medeleg_d;
      mideleg_q  <= mideleg_d;
      stvec_q    <= stvec_d;
      sepc_q     <= sepc_d;
      scause_q   <= scause_d;
      stval_q    <= stval_d;
      satp_q     <= satp_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      priv_q     <= priv_d;
    end
  end

  // EX-stage combinational read mux
  always_comb begin
    rd_impl = 1'b1;
    rdata_o = '0;
    case (raddr_i)
      12'h300: rdata_o = mstatus_q;
      12'h301: rdata_o = MISA_VAL;
      12'h302: rdata_o = medeleg_q;
      12'h303: rdata_o = mideleg_q;
      12'h304: rdata_o = mie_q;
      12'h305: rdata_o = mtvec_q;
      12'h341: rdata_o = mepc_q;
      12'h342: rdata_o = mcause_q;
      12'h343: rdata_o = mtval_q;
      12'h344: rdata_o = mip_rd;
      12'h100: rdata_o = mstatus_q & SSTATUS_MASK;
      12'h104: rdata_o = mie_q & mideleg_q;
      12'h105: rdata_o = stvec_q;
      12'h141: rdata_o = sepc_q;
      12'h142: rdata_o = scause_q;
      12'h143: rdata_o = stval_q;
      12'h144: rdata_o = mip_rd & mideleg_q;
      12'h180: rdata_o = satp_q;
      12'hB00, 12'hC00: rdata_o = mcycle_q[31:0];
      12'hB80, 12'hC80: rdata_o = mcycle_q[63:32];
      12'hB02, 12'hC02: rdata_o = minstret_q[31:0];
      12'hB82, 12'hC82: rdata_o = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: rdata_o = '0;
      12'hF14: rdata_o = HART_ID;
      default: rd_impl = 1'b0;
    endcase
  end

  assign illegal_o = ~rd_impl | (priv_q < raddr_i[9:8])
                   | (inst_we_i & (inst_ro | inst_upriv));

  assign csr_mstatus_o   = mstatus_q;
  assign csr_mtvec_o     = mtvec_q;
  assign csr_mepc_o      = mepc_q;
  assign csr_mcause_o    = mcause_q;
  assign csr_mtval_o     = mtval_q;
  assign csr_mie_o       = mie_q;
  assign csr_mip_o       = mip_rd;
  assign csr_medeleg_o   = medeleg_q;
  assign csr_mideleg_o   = mideleg_q;
  assign csr_stvec_o     = stvec_q;
  assign csr_sepc_o      = sepc_q;
  assign csr_scause_o    = scause_q;
  assign csr_stval_o     = stval_q;
  assign csr_sstatus_o   = mstatus_q & SSTATUS_MASK;
  assign csr_sie_o       = mie_q & mideleg_q;
  assign csr_sip_o       = mip_rd & mideleg_q;
  assign csr_satp_o      = satp_q;
  assign csr_privilege_o = priv_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Testbench for csr_regfile: directed scenarios plus randomized traffic
// checked against a bit-rule reference model.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_we_i = 1'b0;
  logic [11:0] trap_waddr_i = '0;
  logic [31:0] trap_wdata_i = '0;
  logic        inst_we_i = 1'b0;
  logic [11:0] inst_waddr_i = '0;
  logic [31:0] inst_wdata_i = '0;
  logic [11:0] raddr_i = '0;
  logic [31:0] rdata_o;
  logic        illegal_o;
  logic        priv_we_i = 1'b0;
  logic [1:0]  priv_i = 2'b11;
  logic        mtip_i = 1'b0;
  logic        retire_i = 1'b0;
  logic [31:0] csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic [31:0] csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o, csr_stvec_o;
  logic [31:0] csr_sepc_o, csr_scause_o, csr_stval_o, csr_sstatus_o, csr_sie_o;
  logic [31:0] csr_sip_o, csr_satp_o;
  logic [1:0]  csr_privilege_o;

  csr_regfile dut (
    .clk(clk), .rst(rst),
    .trap_we_i(trap_we_i), .trap_waddr_i(trap_waddr_i), .trap_wdata_i(trap_wdata_i),
    .inst_we_i(inst_we_i), .inst_waddr_i(inst_waddr_i), .inst_wdata_i(inst_wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .illegal_o(illegal_o),
    .priv_we_i(priv_we_i), .priv_i(priv_i), .mtip_i(mtip_i), .retire_i(retire_i),
    .csr_mstatus_o(csr_mstatus_o), .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o),
    .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o), .csr_mie_o(csr_mie_o),
    .csr_mip_o(csr_mip_o), .csr_medeleg_o(csr_medeleg_o), .csr_mideleg_o(csr_mideleg_o),
    .csr_stvec_o(csr_stvec_o), .csr_sepc_o(csr_sepc_o), .csr_scause_o(csr_scause_o),
    .csr_stval_o(csr_stval_o), .csr_sstatus_o(csr_sstatus_o), .csr_sie_o(csr_sie_o),
    .csr_sip_o(csr_sip_o), .csr_satp_o(csr_satp_o), .csr_privilege_o(csr_privilege_o)
  );

  always #5 clk = ~clk;

  // Reference model state: storage keyed by CSR address, 64-bit counters
  logic [31:0]     st [logic [11:0]];
  longint unsigned cyc_m, ins_m;
  logic [1:0]      mpriv;
  int              vectors = 0;
  int              errs = 0;
  logic [11:0]     pool [34];

  localparam logic [31:0] MISA = 32'h4014_1105;
  localparam logic [31:0] SMASK = 32'h000C_0122;

  task automatic mreset();
    logic [11:0] keys [14];
    keys = '{12'h300, 12'h302, 12'h303, 12'h304, 12'h305, 12'h341, 12'h342,
             12'h343, 12'h344, 12'h105, 12'h141, 12'h142, 12'h143, 12'h180};
    foreach (keys[k]) st[keys[k]] = 32'h0;
    st[12'h300] = 32'h0000_1800;
    cyc_m = 0;
    ins_m = 0;
    mpriv = 2'b11;
  endtask

  function automatic logic [32:0] mread(input logic [11:0] a);
    logic [31:0] mipv;
    mipv = st[12'h344];
    mipv[7] = mipv[7] | mtip_i;
    case (a)
      12'h300, 12'h302, 12'h303, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343,
      12'h105, 12'h141, 12'h142, 12'h143, 12'h180: return {1'b1, st[a]};
      12'h301: return {1'b1, MISA};
      12'h344: return {1'b1, mipv};
      12'h100: return {1'b1, st[12'h300] & SMASK};
      12'h104: return {1'b1, st[12'h304] & st[12'h303]};
      12'h144: return {1'b1, mipv & st[12'h303]};
      12'hB00, 12'hC00: return {1'b1, 32'(cyc_m % 64'h1_0000_0000)};
      12'hB80, 12'hC80: return {1'b1, 32'(cyc_m / 64'h1_0000_0000)};
      12'hB02, 12'hC02: return {1'b1, 32'(ins_m % 64'h1_0000_0000)};
      12'hB82, 12'hC82: return {1'b1, 32'(ins_m / 64'h1_0000_0000)};
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return {1'b1, 32'h0};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic logic [31:0] mv(input logic [11:0] a);
    logic [32:0] r;
    r = mread(a);
    return r[31:0];
  endfunction

  function automatic logic mill();
    logic [32:0] r;
    r = mread(raddr_i);
    return !r[32] || (mpriv < raddr_i[9:8]) ||
           (inst_we_i && (inst_waddr_i[11:10] == 2'b11 || mpriv < inst_waddr_i[9:8]));
  endfunction

  // Apply one CSR write following the per-bit field rules
  task automatic mwrite(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] dl;
    v = 32'h0;
    dl = st[12'h303];
    case (a)
      12'h300: begin
        for (int i = 0; i < 32; i++)
          if (i inside {1, 3, 5, 7, 8, 11, 12, 18, 19}) v[i] = d[i];
        if (v[12:11] == 2'b10) v[12:11] = 2'b00;
        st[a] = v;
      end
      12'h100: begin
        v = st[12'h300];
        for (int i = 0; i < 32; i++) if (i inside {1, 5, 8, 18, 19}) v[i] = d[i];
        st[12'h300] = v;
      end
      12'h302: begin
        for (int i = 0; i < 16; i++) if (i != 11) v[i] = d[i];
        st[a] = v;
      end
      12'h303: begin
        for (int i = 0; i < 32; i++) if (i inside {1, 5, 9}) v[i] = d[i];
        st[a] = v;
      end
      12'h304, 12'h104: begin
        v = st[12'h304];
        for (int i = 0; i < 32; i++)
          if (a == 12'h304 || dl[i]) v[i] = (i inside {1, 3, 5, 7, 9, 11}) ? d[i] : 1'b0;
        st[12'h304] = v;
      end
      12'h344, 12'h144: begin
        v = st[12'h344];
        for (int i = 0; i < 32; i++)
          if (a == 12'h344 || dl[i]) v[i] = (i inside {1, 5, 7}) ? d[i] : 1'b0;
        st[12'h344] = v;
      end
      12'h305, 12'h105: begin
        v = (d / 4) * 4;
        v = v + ((d % 4 >= 2) ? st[a] % 4 : d % 4);
        st[a] = v;
      end
      12'h341, 12'h141: st[a] = d - (d % 2);
      12'h342, 12'h343, 12'h142, 12'h143, 12'h180: st[a] = d;
      default: ;
    endcase
  endtask

  task automatic mstep();
    logic        ok, we;
    logic [11:0] a;
    logic [31:0] d;
    ok = inst_we_i && inst_waddr_i[11:10] != 2'b11 && mpriv >= inst_waddr_i[9:8];
    we = trap_we_i || ok;
    a  = trap_we_i ? trap_waddr_i : inst_waddr_i;
    d  = trap_we_i ? trap_wdata_i : inst_wdata_i;
    if (we && a == 12'hB00)      cyc_m = (cyc_m / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(d);
    else if (we && a == 12'hB80) cyc_m = (64'(d) * 64'h1_0000_0000) + (cyc_m % 64'h1_0000_0000);
    else                         cyc_m = cyc_m + 1;
    if (we && a == 12'hB02)      ins_m = (ins_m / 64'h1_0000_0000) * 64'h1_0000_0000 + 64'(d);
    else if (we && a == 12'hB82) ins_m = (64'(d) * 64'h1_0000_0000) + (ins_m % 64'h1_0000_0000);
    else if (retire_i)           ins_m = ins_m + 1;
    if (we) mwrite(a, d);
    if (priv_we_i) mpriv = priv_i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("mstatus", csr_mstatus_o, mv(12'h300));
    chk("mtvec", csr_mtvec_o, mv(12'h305));
    chk("mepc", csr_mepc_o, mv(12'h341));
    chk("mcause", csr_mcause_o, mv(12'h342));
    chk("mtval", csr_mtval_o, mv(12'h343));
    chk("mie", csr_mie_o, mv(12'h304));
    chk("mip", csr_mip_o, mv(12'h344));
    chk("medeleg", csr_medeleg_o, mv(12'h302));
    chk("mideleg", csr_mideleg_o, mv(12'h303));
    chk("stvec", csr_stvec_o, mv(12'h105));
    chk("sepc", csr_sepc_o, mv(12'h141));
    chk("scause", csr_scause_o, mv(12'h142));
    chk("stval", csr_stval_o, mv(12'h143));
    chk("sstatus", csr_sstatus_o, mv(12'h100));
    chk("sie", csr_sie_o, mv(12'h104));
    chk("sip", csr_sip_o, mv(12'h144));
    chk("satp", csr_satp_o, mv(12'h180));
    chk("priv", {30'h0, csr_privilege_o}, {30'h0, mpriv});
  endtask

  task automatic chk_comb();
    chk("rdata", rdata_o, mv(raddr_i));
    chk("illegal", {31'h0, illegal_o}, {31'h0, mill()});
  endtask

  // One clock: drive ports, check read port before the edge, registers after
  task automatic cyc(input logic twe, input logic [11:0] twa, input logic [31:0] twd,
                     input logic iwe, input logic [11:0] iwa, input logic [31:0] iwd,
                     input logic [11:0] ra);
    trap_we_i = twe; trap_waddr_i = twa; trap_wdata_i = twd;
    inst_we_i = iwe; inst_waddr_i = iwa; inst_wdata_i = iwd;
    raddr_i = ra;
    #1;
    chk_comb();
    @(posedge clk);
    if (rst) mreset();
    else mstep();
    #1;
    chk_regs();
  endtask

  initial begin
    pool = '{12'h300, 12'h301, 12'h302, 12'h303, 12'h304, 12'h305, 12'h341, 12'h342,
             12'h343, 12'h344, 12'h100, 12'h104, 12'h105, 12'h141, 12'h142, 12'h143,
             12'h144, 12'h180, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
             12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h3A0,
             12'h001, 12'h340};
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk_regs();
    rst = 1'b0;

    // Reset values via read port
    raddr_i = 12'h300; #1;
    chk("t1_mstatus_rd", rdata_o, 32'h0000_1800);
    chk("t1_mstatus_ill", {31'h0, illegal_o}, 32'h0);
    raddr_i = 12'hF14; #1;
    chk("t1_hartid_rd", rdata_o, 32'h0);
    chk("t1_hartid_ill", {31'h0, illegal_o}, 32'h0);
    chk("t1_priv", {30'h0, csr_privilege_o}, 32'h3);

    // Trap controller sequence
    cyc(1'b1, 12'h341, 32'h8000_0101, 1'b0, 12'h0, 32'h0, 12'h341);
    chk("t2_mepc", csr_mepc_o, 32'h8000_0100);
    cyc(1'b1, 12'h342, 32'h8000_0007, 1'b0, 12'h0, 32'h0, 12'h341);
    chk("t2_mcause", csr_mcause_o, 32'h8000_0007);
    cyc(1'b1, 12'h300, 32'h0000_1880, 1'b0, 12'h0, 32'h0, 12'h300);
    chk("t2_mstatus", csr_mstatus_o, 32'h0000_1880);

    // Simultaneous writes: trap wins, instruction write is dropped
    cyc(1'b1, 12'h341, 32'h100, 1'b1, 12'h341, 32'h200, 12'h341);
    chk("t3_mepc", csr_mepc_o, 32'h100);
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 12'h341);
    chk("t3_mepc_hold", csr_mepc_o, 32'h100);

    // Delegated interrupt enables and timer pending
    cyc(1'b1, 12'h303, 32'h222, 1'b0, 12'h0, 32'h0, 12'h303);
    cyc(1'b1, 12'h304, 32'h0, 1'b0, 12'h0, 32'h0, 12'h304);
    cyc(1'b0, 12'h0, 32'h0, 1'b1, 12'h104, 32'hFFFF_FFFF, 12'h104);
    chk("t4_mie", csr_mie_o, 32'h222);
    chk("t4_sie", csr_sie_o, 32'h222);
    mtip_i = 1'b1;
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 12'h344);
    chk("t4_mip7", csr_mip_o & 32'h80, 32'h80);
    chk("t4_sip7", csr_sip_o & 32'h80, 32'h0);
    mtip_i = 1'b0;

    // MPP WARL and privilege checks
    cyc(1'b0, 12'h0, 32'h0, 1'b1, 12'h300, 32'h0000_1000, 12'h300);
    chk("t5_mpp", csr_mstatus_o & 32'h1800, 32'h0);
    priv_we_i = 1'b1; priv_i = 2'b00;
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 12'h300);
    priv_we_i = 1'b0;
    chk("t5_priv_u", {30'h0, csr_privilege_o}, 32'h0);
    raddr_i = 12'h300; #1;
    chk("t5_ill_rd", {31'h0, illegal_o}, 32'h1);
    cyc(1'b0, 12'h0, 32'h0, 1'b1, 12'hC00, 32'h55, 12'hC00);
    inst_we_i = 1'b1; inst_waddr_i = 12'hC00; raddr_i = 12'hF14; #1;
    chk("t5_ill_ro_wr", {31'h0, illegal_o}, 32'h1);
    cyc(1'b0, 12'h0, 32'h0, 1'b1, 12'h341, 32'h9999, 12'hC00);
    chk("t5_upriv_wr_ignored", csr_mepc_o, 32'h100);
    priv_we_i = 1'b1; priv_i = 2'b11;
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 12'hC00);
    priv_we_i = 1'b0;

    // 64-bit counter carry and mtvec mode retention
    cyc(1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 12'h0, 32'h0, 12'hB00);
    cyc(1'b1, 12'hB80, 32'h0, 1'b0, 12'h0, 32'h0, 12'hB80);
    cyc(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 32'h0, 12'hB00);
    raddr_i = 12'hB00; #1;
    chk("t6_mcycle_lo", rdata_o, 32'h0);
    raddr_i = 12'hC80; #1;
    chk("t6_mcycle_hi", rdata_o, 32'h1);
    cyc(1'b1, 12'h305, 32'h8000_0003, 1'b0, 12'h0, 32'h0, 12'h305);
    chk("t6_mtvec", csr_mtvec_o, 32'h8000_0000);

    // Reset in the middle of a trap sequence
    cyc(1'b1, 12'h341, 32'h1234, 1'b0, 12'h0, 32'h0, 12'h341);
    trap_we_i = 1'b1; trap_waddr_i = 12'h342; trap_wdata_i = 32'h5;
    #2;
    rst = 1'b1;
    #1;
    mreset();
    chk_regs();
    chk("rst_mepc", csr_mepc_o, 32'h0);
    cyc(1'b1, 12'h342, 32'h5, 1'b0, 12'h0, 32'h0, 12'hB00);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] p;
      mtip_i    = 1'($urandom_range(0, 1));
      retire_i  = 1'($urandom_range(0, 1));
      priv_we_i = ($urandom_range(0, 9) == 0);
      p         = 2'($urandom_range(0, 2));
      priv_i    = (p == 2'd2) ? 2'b11 : p;
      cyc(($urandom_range(0, 9) < 3), pool[$urandom_range(0, 33)], $urandom(),
          ($urandom_range(0, 9) < 4), pool[$urandom_range(0, 33)], $urandom(),
          pool[$urandom_range(0, 33)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
